uart_tx_fifo: RTL and testbench

- Byte-oriented UART transmitter (8N1, LSB first) with a small input FIFO.
- It is the transmit counterpart of the serial receive path that the cocotb bench decodes on a `uo_out` pin.
- Upstream logic pushes bytes over a valid/ready handshake. The block serialises them back-to-back on `tx` with no idle gap while data is queued.

---
 rtl/uart_tx_fifo.sv | 140 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter (LSB first) fed by a small valid/ready byte FIFO.
// Queued bytes are sent back-to-back with no idle gap between frames.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_d;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            rdy_q;
  logic            full, empty, push, pop, baud_last;

  assign full      = (fifo_count == DEPTH_C);
  assign empty     = (fifo_count == '0);
  // rdy_q delays readiness until the first edge that samples rst_n high.
  assign in_ready  = ena & rst_n & rdy_q & ~full;
  assign push      = in_valid & in_ready;
  assign busy      = (state_q != IDLE) | ~empty;
  assign baud_last = (baud_q == BAUD_LAST);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data waits.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx         <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (ena) begin
        state_q <= state_d;
        baud_q  <= baud_d;
        bit_q   <= bit_d;
        shift_q <= shift_d;
        tx      <= tx_d;
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CNT_ONE;
          2'b01:   fifo_count <= fifo_count - CNT_ONE;
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: table-driven fill sequence, hand-written
// corner cases and a randomized run checked against a byte-stream model.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FLEN  = 10 * CPB;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    int   at;
    int   cnt;
    logic rdy;
    logic txv;
    logic bsy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [$clog2(DEPTH):0] fifo_count;

  int total = 0;
  int bad   = 0;

  logic       log_on = 1'b0;
  logic       ena_s  = 1'b0;
  logic       tx_log[$];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Record tx once per enabled clock edge; frozen cycles are skipped.
  always @(posedge clk) ena_s <= ena;
  always @(negedge clk) if (log_on && ena_s) tx_log.push_back(tx);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [FLEN-1:0] frame_bits(input logic [7:0] b);
    logic [9:0]      sym;
    logic [FLEN-1:0] f;
    sym = {1'b1, b, 1'b0};
    for (int j = 0; j < FLEN; j++) f[j] = sym[j / CPB];
    return f;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; ena = 1'b1; in_data = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin cyc(); n++; end
    check({name, " drain"}, busy, 1'b0);
    repeat (3) cyc();
  endtask

  // Compare recorded line activity against back-to-back 8N1 frames of exp.
  task automatic check_log(input string name, input byte_q_t exp);
    int first = -1;
    int zeros = 0;
    logic [FLEN-1:0] act;
    foreach (tx_log[i]) if (first < 0 && tx_log[i] == 1'b0) first = i;
    check({name, " start seen"}, first >= 0, 1'b1);
    if (first < 0) first = tx_log.size();
    for (int k = 0; k < exp.size(); k++) begin
      for (int j = 0; j < FLEN; j++) begin
        int idx = first + k * FLEN + j;
        act[j] = (idx < tx_log.size()) ? tx_log[idx] : 1'bx;
      end
      check($sformatf("%s frame %0d", name, k), act, frame_bits(exp[k]));
    end
    for (int i = first + exp.size() * FLEN; i < tx_log.size(); i++)
      if (tx_log[i] == 1'b0) zeros++;
    check({name, " idle tail"}, zeros, 0);
  endtask

  initial begin
    vec_t        vecs[$];
    byte_q_t     exp_q;
    logic [FLEN-1:0] f;
    int          nxt, vi, zeros;
    logic        acc;

    // ---- reset values ----
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("rst tx %0d", i), tx, 1'b1);
      check($sformatf("rst busy %0d", i), busy, 1'b0);
      check($sformatf("rst count %0d", i), fifo_count, 0);
      check($sformatf("rst in_ready %0d", i), in_ready, 1'b0);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check("ready before sampled release", in_ready, 1'b0);
    cyc();
    check("ready after release", in_ready, 1'b1);
    check("idle tx after release", tx, 1'b1);

    // ---- single byte 0xA5 ----
    do_reset();
    in_valid = 1'b1; in_data = 8'hA5;
    cyc();
    in_valid = 1'b0; in_data = 8'h00;
    check("single count after push", fifo_count, 1);
    check("single busy after push", busy, 1'b1);
    check("single tx after push", tx, 1'b1);
    cyc();
    check("single count after pop", fifo_count, 0);
    check("single tx before start", tx, 1'b1);
    f = frame_bits(8'hA5);
    for (int j = 0; j < FLEN; j++) begin
      cyc();
      check($sformatf("single tx bit %0d", j), tx, f[j]);
      if (j == FLEN / 2) check("single busy mid", busy, 1'b1);
    end
    cyc();
    check("single busy after frame", busy, 1'b0);
    check("single tx idle", tx, 1'b1);

    // ---- FIFO fill, full stall, same-cycle pop ----
    vecs.push_back('{at: 0,  cnt: 1, rdy: 1'b1, txv: 1'b1, bsy: 1'b1});
    vecs.push_back('{at: 1,  cnt: 1, rdy: 1'b1, txv: 1'b1, bsy: 1'b1});
    vecs.push_back('{at: 2,  cnt: 2, rdy: 1'b1, txv: 1'b0, bsy: 1'b1});
    vecs.push_back('{at: 4,  cnt: 4, rdy: 1'b0, txv: 1'b0, bsy: 1'b1});
    vecs.push_back('{at: 5,  cnt: 4, rdy: 1'b0, txv: 1'b0, bsy: 1'b1});
    vecs.push_back('{at: 6,  cnt: 4, rdy: 1'b0, txv: 1'b1, bsy: 1'b1});
    vecs.push_back('{at: 10, cnt: 4, rdy: 1'b0, txv: 1'b0, bsy: 1'b1});
    vecs.push_back('{at: 37, cnt: 4, rdy: 1'b0, txv: 1'b0, bsy: 1'b1});
    vecs.push_back('{at: 38, cnt: 4, rdy: 1'b0, txv: 1'b1, bsy: 1'b1});
    vecs.push_back('{at: 41, cnt: 3, rdy: 1'b1, txv: 1'b1, bsy: 1'b1});
    vecs.push_back('{at: 42, cnt: 4, rdy: 1'b0, txv: 1'b0, bsy: 1'b1});
    do_reset();
    tx_log.delete(); log_on = 1'b1;
    nxt = 1; vi = 0;
    in_valid = 1'b1; in_data = 8'(nxt);
    for (int c = 0; c <= 42; c++) begin
      #1;
      acc = in_valid & in_ready;
      cyc();
      if (acc) nxt++;
      in_valid = (nxt <= 6);
      in_data  = 8'(nxt);
      if (vi < vecs.size() && vecs[vi].at == c) begin
        check($sformatf("fill count e%0d", c), fifo_count, vecs[vi].cnt);
        check($sformatf("fill ready e%0d", c), in_ready, vecs[vi].rdy);
        check($sformatf("fill tx e%0d", c), tx, vecs[vi].txv);
        check($sformatf("fill busy e%0d", c), busy, vecs[vi].bsy);
        vi++;
      end
    end
    check("fill all accepted", nxt, 7);
    in_valid = 1'b0;
    wait_idle("fill", 8 * FLEN);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    check_log("fill", exp_q);
    log_on = 1'b0;

    // ---- ena freeze mid DATA bit 3 of 0x3C ----
    do_reset();
    tx_log.delete(); log_on = 1'b1;
    in_valid = 1'b1; in_data = 8'h3C;
    cyc();
    in_valid = 1'b0;
    repeat (19) cyc();
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check($sformatf("frozen tx %0d", i), tx, 1'b1);
      check($sformatf("frozen ready %0d", i), in_ready, 1'b0);
    end
    check("frozen busy", busy, 1'b1);
    ena = 1'b1;
    wait_idle("ena", 2 * FLEN);
    exp_q = '{8'h3C};
    check_log("ena", exp_q);
    log_on = 1'b0;

    // ---- reset mid-frame with bytes queued ----
    do_reset();
    in_valid = 1'b1;
    in_data = 8'h11; cyc();
    in_data = 8'h22; cyc();
    in_data = 8'h33; cyc();
    in_valid = 1'b0;
    check("abort queued count", fifo_count, 2);
    repeat (8) cyc();
    check("abort tx low before reset", tx, 1'b0);
    rst_n = 1'b0;
    cyc();
    check("abort tx", tx, 1'b1);
    check("abort count", fifo_count, 0);
    check("abort busy", busy, 1'b0);
    rst_n = 1'b1;
    zeros = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (tx == 1'b0) zeros++;
    end
    check("abort no restart", zeros, 0);
    check("abort idle busy", busy, 1'b0);

    // ---- randomized traffic against byte-stream model ----
    do_reset();
    tx_log.delete(); log_on = 1'b1;
    exp_q = {};
    for (int c = 0; c < 1500; c++) begin
      ena      = ($urandom_range(0, 7) != 0);
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = 8'($urandom());
      #1;
      check($sformatf("rand ready c%0d", c), in_ready,
            ena && (fifo_count < DEPTH));
      if (fifo_count > DEPTH) check($sformatf("rand overflow c%0d", c), fifo_count, DEPTH);
      if (in_valid && in_ready) exp_q.push_back(in_data);
      cyc();
    end
    in_valid = 1'b0; ena = 1'b1;
    wait_idle("rand", (DEPTH + 2) * FLEN);
    check_log("rand", exp_q);
    log_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
